alu_seq: RTL and testbench

Registered, parametrised successor to the 16-bit combinational ALU. It adds a start/done handshake, a persistent flag register with real carry and overflow semantics, carry-chained add/subtract, and an iterative shift-add multiplier that trades WIDTH cycles for area. It sits in the execute stage: the controller issues one operation, waits for `done`, then reads `result` and `status_reg`.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_mul_iter.sv | 58 +++++
 rtl/alu_seq.sv | 129 ++++++++++++
 tb/tb_alu_seq.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, flag positions, FSM encoding and status packing for alu_seq.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SBB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  localparam int unsigned FLAG_Z = 15;
  localparam int unsigned FLAG_N = 14;
  localparam int unsigned FLAG_C = 13;
  localparam int unsigned FLAG_V = 12;

  localparam int unsigned STATUS_W = 16;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  // Pack the four flags into the status word; low bits are always zero.
  function automatic logic [STATUS_W-1:0] pack_status(input logic z, input logic n,
                                                      input logic c, input logic v);
    logic [STATUS_W-1:0] s;
    s         = '0;
    s[FLAG_Z] = z;
    s[FLAG_N] = n;
    s[FLAG_C] = c;
    s[FLAG_V] = v;
    return s;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done_c,
  output logic [2*WIDTH-1:0] prod_c,
  output logic [WIDTH-1:0]   a_lat,
  output logic [WIDTH-1:0]   b_lat
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  logic [W2-1:0] acc;
  logic [CW-1:0] cnt;
  logic          active;
  logic [W2-1:0] addend_c;

  // Partial product for this iteration; prod_c is the accumulator after it,
  // so the full product is available combinationally on the final iteration.
  always_comb begin
    addend_c = '0;
    if (b_lat[cnt]) addend_c = W2'(a_lat) << cnt;
    prod_c = acc + addend_c;
    done_c = active && (cnt == CW'(WIDTH - 1));
  end

  // Operand latch, accumulator and iteration counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      cnt    <= '0;
      active <= 1'b0;
      a_lat  <= '0;
      b_lat  <= '0;
    end else if (start) begin
      a_lat  <= a;
      b_lat  <= b;
      acc    <= '0;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      acc <= prod_c;
      if (done_c) begin
        cnt    <= '0;
        active <= 1'b0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/done handshake, persistent flags and iterative multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [WIDTH-1:0]    data1,
  input  logic [WIDTH-1:0]    data2,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    result,
  output logic [STATUS_W-1:0] status_reg
);

  localparam int unsigned W1 = WIDTH + 1;
  localparam int unsigned W2 = 2 * WIDTH;

  state_t             state;
  logic               mul_start_c;
  logic               mul_done_c;
  logic [W2-1:0]      mul_prod_c;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;

  logic [W1-1:0]      wide_c;
  logic [WIDTH-1:0]   alu_res_c;
  logic               alu_c_c;
  logic               alu_v_c;
  logic [WIDTH-1:0]   mul_lo_c;
  logic [WIDTH-1:0]   mul_hi_c;
  logic [WIDTH-1:0]   mul_h_c;
  logic               c_in;

  assign c_in        = status_reg[FLAG_C];
  assign mul_start_c = (state == S_IDLE) && start && (op == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start_c),
    .a      (data1),
    .b      (data2),
    .done_c (mul_done_c),
    .prod_c (mul_prod_c),
    .a_lat  (mul_a),
    .b_lat  (mul_b)
  );

  // Single-cycle datapath; the extra top bit of wide_c carries carry/borrow/shift-out.
  always_comb begin
    wide_c    = '0;
    alu_res_c = '0;
    alu_c_c   = 1'b0;
    alu_v_c   = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        wide_c    = {1'b0, data1} + {1'b0, data2} + W1'((op == OP_ADC) && c_in);
        alu_res_c = wide_c[WIDTH-1:0];
        alu_c_c   = wide_c[WIDTH];
        alu_v_c   = (data1[WIDTH-1] == data2[WIDTH-1]) && (alu_res_c[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        wide_c    = {1'b0, data1} - {1'b0, data2} - W1'((op == OP_SBB) && c_in);
        alu_res_c = wide_c[WIDTH-1:0];
        alu_c_c   = wide_c[WIDTH];
        alu_v_c   = (data1[WIDTH-1] != data2[WIDTH-1]) && (alu_res_c[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_AND: alu_res_c = data1 & data2;
      OP_SHL: begin
        // Bit WIDTH of the widened shift is A[WIDTH-s] for 1<=s<=WIDTH, else zero.
        wide_c    = {1'b0, data1} << data2;
        alu_res_c = wide_c[WIDTH-1:0];
        alu_c_c   = wide_c[WIDTH];
      end
      OP_MOV: alu_res_c = data2;
      default: alu_res_c = '0;
    endcase
  end

  // Multiply flags: signed high half recovered from the unsigned product.
  always_comb begin
    mul_lo_c = mul_prod_c[WIDTH-1:0];
    mul_hi_c = mul_prod_c[W2-1:WIDTH];
    mul_h_c  = mul_hi_c - (mul_a[WIDTH-1] ? mul_b : '0) - (mul_b[WIDTH-1] ? mul_a : '0);
  end

  // Control FSM with registered result, flags, busy and done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      status_reg <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              state <= S_MUL;
              busy  <= 1'b1;
            end else begin
              result     <= alu_res_c;
              status_reg <= pack_status(alu_res_c == '0, alu_res_c[WIDTH-1], alu_c_c, alu_v_c);
              done       <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (mul_done_c) begin
            result     <= mul_lo_c;
            status_reg <= pack_status(mul_lo_c == '0, mul_lo_c[WIDTH-1], |mul_hi_c,
                                      mul_h_c != {WIDTH{mul_lo_c[WIDTH-1]}});
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=16 and WIDTH=8.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st  = 1'b0;
  logic        sel8 = 1'b0;
  logic [2:0]  op  = 3'b000;
  logic [15:0] a   = '0;
  logic [15:0] b   = '0;

  logic        bz16, dn16, bz8, dn8;
  logic [15:0] res16, stat16, stat8;
  logic [7:0]  res8;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(st & ~sel8), .op(op), .data1(a), .data2(b),
    .busy(bz16), .done(dn16), .result(res16), .status_reg(stat16)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st & sel8), .op(op), .data1(a[7:0]), .data2(b[7:0]),
    .busy(bz8), .done(dn8), .result(res8), .status_reg(stat8)
  );

  wire        cur_busy = sel8 ? bz8 : bz16;
  wire        cur_done = sel8 ? dn8 : dn16;
  wire [15:0] cur_res  = sel8 ? {8'h00, res8} : res16;
  wire [15:0] cur_stat = sel8 ? stat8 : stat16;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Issue one op, wait (bounded) for done, check latency/result/status.
  // stray: pulse start with other operands while busy. chain: return on the done cycle.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [15:0] va,
                       input logic [15:0] vb, input int lat, input logic [15:0] er,
                       input logic [15:0] es, input bit stray, input bit chain);
    int n;
    st = 1'b1; op = o; a = va; b = vb;
    tick();
    st = 1'b0;
    n = 0;
    while (!cur_done && n < 40) begin
      chk({tag, " busy"}, 32'(cur_busy), 32'(1));
      if (stray && n >= 2 && n <= 4) begin
        st = 1'b1; op = OP_ADD; a = 16'h0001; b = 16'h0001;
      end else begin
        st = 1'b0; a = va; b = vb;
      end
      tick();
      n++;
    end
    st = 1'b0;
    chk({tag, " latency"}, 32'(n), 32'(lat));
    chk({tag, " result"}, 32'(cur_res), 32'(er));
    chk({tag, " status"}, 32'(cur_stat), 32'(es));
    chk({tag, " busy_at_done"}, 32'(cur_busy), 32'(0));
    if (!chain) begin
      tick();
      chk({tag, " done_drop"}, 32'(cur_done), 32'(0));
      chk({tag, " idle_after"}, 32'(cur_busy), 32'(0));
    end
  endtask

  initial begin
    int pulses;
    tick();
    tick();
    chk("rst result", 32'(res16), 32'(0));
    chk("rst status", 32'(stat16), 32'(0));
    chk("rst busy", 32'(bz16), 32'(0));
    chk("rst done", 32'(dn16), 32'(0));
    rst = 1'b0;
    tick();

    do_op("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 0, 16'h8000, 16'h5000, 0, 0);
    do_op("add_zc",  OP_ADD, 16'hFFFF, 16'h0001, 0, 16'h0000, 16'hA000, 0, 0);
    do_op("adc",     OP_ADC, 16'h0001, 16'h0001, 0, 16'h0003, 16'h0000, 0, 0);
    do_op("sub",     OP_SUB, 16'h0003, 16'h0005, 0, 16'hFFFE, 16'h6000, 0, 0);
    do_op("sbb",     OP_SBB, 16'h0010, 16'h0001, 0, 16'h000E, 16'h0000, 0, 0);
    do_op("mul_neg", OP_MUL, 16'hFFFF, 16'h0002, 16, 16'hFFFE, 16'h6000, 1, 0);
    do_op("mul_ovf", OP_MUL, 16'h0100, 16'h0100, 16, 16'h0000, 16'hB000, 0, 0);
    do_op("mul_m1",  OP_MUL, 16'hFFFF, 16'hFFFF, 16, 16'h0001, 16'h2000, 0, 1);

    // Start on the done cycle is accepted; reset mid-multiply discards it.
    st = 1'b1; op = OP_MUL; a = 16'h0003; b = 16'h0005;
    tick();
    st = 1'b0;
    chk("b2b accepted", 32'(bz16), 32'(1));
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    chk("midrst result", 32'(res16), 32'(0));
    chk("midrst status", 32'(stat16), 32'(0));
    chk("midrst busy", 32'(bz16), 32'(0));
    chk("midrst done", 32'(dn16), 32'(0));
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dn16 || bz16) pulses++;
    end
    chk("midrst no_done", 32'(pulses), 32'(0));

    do_op("add_post", OP_ADD, 16'h0002, 16'h0003, 0, 16'h0005, 16'h0000, 0, 0);
    do_op("shl1",     OP_SHL, 16'h8001, 16'h0001, 0, 16'h0002, 16'h2000, 0, 0);
    do_op("shl16",    OP_SHL, 16'h8001, 16'h0010, 0, 16'h0000, 16'hA000, 0, 0);
    do_op("shl20",    OP_SHL, 16'h8001, 16'h0014, 0, 16'h0000, 16'h8000, 0, 0);
    do_op("shl0",     OP_SHL, 16'h8001, 16'h0000, 0, 16'h8001, 16'h4000, 0, 0);
    do_op("and",      OP_AND, 16'hF0F0, 16'h0FF0, 0, 16'h00F0, 16'h0000, 0, 0);
    do_op("mov",      OP_MOV, 16'h1234, 16'h8000, 0, 16'h8000, 16'h4000, 0, 0);

    sel8 = 1'b1;
    do_op("w8 add_ovf", OP_ADD, 16'h007F, 16'h0001, 0, 16'h0080, 16'h5000, 0, 0);
    do_op("w8 shl1",    OP_SHL, 16'h0081, 16'h0001, 0, 16'h0002, 16'h2000, 0, 0);
    do_op("w8 shl8",    OP_SHL, 16'h0081, 16'h0008, 0, 16'h0000, 16'hA000, 0, 0);
    do_op("w8 shl9",    OP_SHL, 16'h0081, 16'h0009, 0, 16'h0000, 16'h8000, 0, 0);
    do_op("w8 mul",     OP_MUL, 16'h00FF, 16'h0002, 8, 16'h00FE, 16'h6000, 1, 0);
    do_op("w8 sbb",     OP_SBB, 16'h0010, 16'h0001, 0, 16'h000E, 16'h0000, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
